// File: rtl/ecc_dec_pipe.sv
// Two-stage SECDED decoder for ecc_enc codewords: stage 1 computes syndrome and
// overall parity, stage 2 corrects/classifies. Optional error counters: ECC_DEC_CNT_EN.
module ecc_dec_pipe #(
    parameter int K       = 8,
    parameter bit P0_LSB  = 1'b1,
    localparam int M      = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1))),
    localparam int N      = M + K
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N:0]    q_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [K-1:0]  d_o,
    output logic          sb_err_o,
    output logic          db_err_o,
    output logic [M-1:0]  syn_o,
    output logic          valid_o,
    input  logic          ready_i,
    input  logic          cnt_clr_i,
    output logic [15:0]   sb_cnt_o,
    output logic [15:0]   db_cnt_o
);

    // Codeword position (1..N) of information bit b: b-th non-power-of-2 position.
    function automatic int data_pos(input int b);
        int c;
        c = 0;
        data_pos = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                if (c == b && data_pos == 0) data_pos = j;
                c++;
            end
        end
    endfunction

    logic [N:1]   cw_in;
    logic [M-1:0] syn_in;
    logic [K-1:0] data_in;
    logic         pf_in;

    generate
        if (P0_LSB) begin : g_p0_lsb
            assign cw_in = q_i[N:1];
        end else begin : g_p0_msb
            assign cw_in = q_i[N-1:0];
        end
    endgenerate

    // p0 only contributes through the overall parity.
    assign pf_in = ^q_i;

    always_comb begin
        syn_in = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 1; j <= N; j++) begin
                if (((j >> i) & 1) == 1) syn_in[i] = syn_in[i] ^ cw_in[j];
            end
        end
    end

    logic         s1_vld;
    logic [K-1:0] s1_data;
    logic [M-1:0] s1_syn;
    logic         s1_pf;
    logic         s1_load;
    logic         s2_load;

    // Handshake: a word moves on a cycle where valid and ready are both high; a stage
    // loads when it is empty or its successor loads, so ready_o depends on ready_i only.
    assign s2_load = ~valid_o | ready_i;
    assign s1_load = ~s1_vld | s2_load;
    assign ready_o = s1_load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_syn  <= '0;
            s1_pf   <= 1'b0;
        end else if (s1_load) begin
            s1_vld <= valid_i;
            if (valid_i) begin
                s1_data <= data_in;
                s1_syn  <= syn_in;
                s1_pf   <= pf_in;
            end
        end
    end

    logic         syn_nz;
    logic         in_range;
    logic         flip;
    logic         single_err;
    logic         double_err;
    logic [K-1:0] d_fix;

    assign syn_nz     = |s1_syn;
    assign in_range   = (s1_syn <= M'(N));
    assign flip       = s1_pf & syn_nz & in_range;
    assign single_err = s1_pf & in_range;
    assign double_err = syn_nz & (~s1_pf | ~in_range);

    // Only information positions are kept; a flip aimed at a parity position leaves data alone.
    generate
        for (genvar b = 0; b < K; b++) begin : g_data
            localparam int DP = data_pos(b);
            assign data_in[b] = cw_in[DP];
            assign d_fix[b]   = s1_data[b] ^ (flip & (s1_syn == M'(DP)));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o  <= 1'b0;
            d_o      <= '0;
            sb_err_o <= 1'b0;
            db_err_o <= 1'b0;
            syn_o    <= '0;
        end else if (s2_load) begin
            valid_o <= s1_vld;
            if (s1_vld) begin
                d_o      <= d_fix;
                sb_err_o <= single_err;
                db_err_o <= double_err;
                syn_o    <= s1_syn;
            end
        end
    end

`ifdef ECC_DEC_CNT_EN
    logic out_hs;
    assign out_hs = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_cnt_o <= '0;
            db_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            sb_cnt_o <= '0;
            db_cnt_o <= '0;
        end else if (out_hs) begin
            if (sb_err_o && sb_cnt_o != 16'hFFFF) sb_cnt_o <= sb_cnt_o + 16'd1;
            if (db_err_o && db_cnt_o != 16'hFFFF) db_cnt_o <= db_cnt_o + 16'd1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign sb_cnt_o       = '0;
    assign db_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Scoreboard bench for ecc_dec_pipe (K=8, P0_LSB=1): encoder model drives codewords,
// expected {d, sb, db, syn} is queued at input handshake and compared at the output.
module tb_ecc_dec_pipe;
    localparam int K  = 8;
    localparam int M  = 4;
    localparam int N  = 12;
    localparam int EW = K + 2 + M;
`ifdef ECC_DEC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N:0]    q_i;
    logic          valid_i;
    logic          ready_o;
    logic [K-1:0]  d_o;
    logic          sb_err_o;
    logic          db_err_o;
    logic [M-1:0]  syn_o;
    logic          valid_o;
    logic          ready_i;
    logic          cnt_clr_i;
    logic [15:0]   sb_cnt_o;
    logic [15:0]   db_cnt_o;

    ecc_dec_pipe #(.K(K), .P0_LSB(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .q_i(q_i), .valid_i(valid_i), .ready_o(ready_o),
        .d_o(d_o), .sb_err_o(sb_err_o), .db_err_o(db_err_o), .syn_o(syn_o),
        .valid_o(valid_o), .ready_i(ready_i), .cnt_clr_i(cnt_clr_i),
        .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];
    int lat_q[$];
    bit chk_lat = 1'b0;
    bit bp_rand = 1'b0;
    int exp_sb = 0;
    int exp_db = 0;
    logic [EW-1:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N:0] enc(input logic [K-1:0] d);
        logic [N:0] q;
        int idx;
        q = '0;
        idx = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                q[j] = d[idx];
                idx++;
            end
        end
        for (int i = 0; i < M; i++)
            for (int j = 1; j <= N; j++)
                if (((j >> i) & 1) == 1 && (j & (j - 1)) != 0) q[1 << i] = q[1 << i] ^ q[j];
        q[0] = ^q[N:1];
        return q;
    endfunction

    function automatic logic [K-1:0] extract(input logic [N:0] q);
        logic [K-1:0] d;
        int idx;
        d = '0;
        idx = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[idx] = q[j];
                idx++;
            end
        end
        return d;
    endfunction

    function automatic logic [EW-1:0] pack(input logic [K-1:0] d, input logic sb,
                                           input logic db, input logic [M-1:0] syn);
        return {d, sb, db, syn};
    endfunction

    // scoreboard / monitor: the queue head must be on the outputs for every valid cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("out", {18'd0, d_o, sb_err_o, db_err_o, syn_o}, {18'd0, mon_e});
                    if (ready_i) begin
                        if (chk_lat) check("latency", cyc - lat_q[0], 2);
                        if (!cnt_clr_i) begin
                            if (mon_e[M+1] && exp_sb != 65535) exp_sb++;
                            if (mon_e[M] && exp_db != 65535) exp_db++;
                        end
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
            if (cnt_clr_i) begin
                exp_sb = 0;
                exp_db = 0;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [N:0] q, input logic [EW-1:0] e);
        int w;
        w = 0;
        valid_i = 1'b1;
        q_i = q;
        @(negedge clk);
        while (!ready_o && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("send_accept", {31'd0, ready_o}, 32'd1);
        if (ready_o) begin
            exp_q.push_back(e);
            lat_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_sb"}, {16'd0, sb_cnt_o}, CNT_EN ? exp_sb : 0);
        check({tag, "_db"}, {16'd0, db_cnt_o}, CNT_EN ? exp_db : 0);
    endtask

    logic [K-1:0] rd;
    logic [N:0]   rq;
    int           kind, pa, pb;

    initial begin
        rst_n = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        cnt_clr_i = 1'b0;
        q_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_fields", {18'd0, d_o, sb_err_o, db_err_o, syn_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_sb_cnt", {16'd0, sb_cnt_o}, 32'd0);
        check("rst_db_cnt", {16'd0, db_cnt_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clean stream, back-to-back, fixed 2-cycle latency
        chk_lat = 1'b1;
        send(enc(8'h00), pack(8'h00, 1'b0, 1'b0, 4'd0));
        send(enc(8'hA5), pack(8'hA5, 1'b0, 1'b0, 4'd0));
        send(enc(8'hFF), pack(8'hFF, 1'b0, 1'b0, 4'd0));
        drain();

        // every single-bit flip; bit j is position j, bit 0 is p0
        for (int b = 0; b <= N; b++) begin
            rq = enc(8'hA5);
            rq[b] = ~rq[b];
            send(rq, pack(8'hA5, 1'b1, 1'b0, 4'(b)));
        end
        drain();
        check("sb_cnt_13", {16'd0, sb_cnt_o}, CNT_EN ? 32'd13 : 32'd0);
        check_cnt("single");

        // double flip at positions 3 and 5 (both data bits d0, d1): data 3C -> 3F uncorrected
        rq = enc(8'h3C);
        rq[3] = ~rq[3];
        rq[5] = ~rq[5];
        send(rq, pack(8'h3F, 1'b0, 1'b1, 4'd6));
        drain();
        check("db_cnt_1", {16'd0, db_cnt_o}, CNT_EN ? 32'd1 : 32'd0);

        // triple flip on parity positions 1,4,8: syndrome 13 > n with odd parity
        rq = enc(8'h5A);
        rq[1] = ~rq[1];
        rq[4] = ~rq[4];
        rq[8] = ~rq[8];
        send(rq, pack(8'h5A, 1'b0, 1'b1, 4'd13));
        drain();
        check_cnt("oor");
        chk_lat = 1'b0;

        // backpressure: 4-word burst with ready_i low for 5 cycles
        ready_i = 1'b0;
        fork
            begin
                send(enc(8'h11), pack(8'h11, 1'b0, 1'b0, 4'd0));
                send(enc(8'h22), pack(8'h22, 1'b0, 1'b0, 4'd0));
                send(enc(8'h33), pack(8'h33, 1'b0, 1'b0, 4'd0));
                send(enc(8'h44), pack(8'h44, 1'b0, 1'b0, 4'd0));
            end
            begin
                @(negedge clk);
                check("bp_ready_empty", {31'd0, ready_o}, 32'd1);
                @(negedge clk);
                check("bp_ready_one", {31'd0, ready_o}, 32'd1);
                @(negedge clk);
                check("bp_ready_full", {31'd0, ready_o}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // random mix of clean, single and double words under random backpressure
        bp_rand = 1'b1;
        fork
            while (bp_rand) begin
                @(posedge clk);
                #1;
                ready_i = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            rq = enc(rd);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                send(rq, pack(rd, 1'b0, 1'b0, 4'd0));
            end else if (kind == 1) begin
                pa = $urandom_range(0, N);
                rq[pa] = ~rq[pa];
                send(rq, pack(rd, 1'b1, 1'b0, 4'(pa)));
            end else begin
                pa = $urandom_range(1, N);
                pb = $urandom_range(1, N - 1);
                if (pb >= pa) pb++;
                rq[pa] = ~rq[pa];
                rq[pb] = ~rq[pb];
                send(rq, pack(extract(rq), 1'b0, 1'b1, 4'(pa ^ pb)));
            end
        end
        bp_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ready_i = 1'b1;
        drain();
        check_cnt("random");

        // saturation: 65537 single errors
        for (int i = 0; i < 65537; i++) begin
            rq = enc(i[7:0]);
            rq[i % 13] = ~rq[i % 13];
            send(rq, pack(i[7:0], 1'b1, 1'b0, 4'(i % 13)));
        end
        drain();
        check("sb_sat", {16'd0, sb_cnt_o}, CNT_EN ? 32'h0000FFFF : 32'd0);
        check_cnt("sat");

        // clear held across an error handshake wins over the increment
        cnt_clr_i = 1'b1;
        rq = enc(8'h77);
        rq[6] = ~rq[6];
        send(rq, pack(8'h77, 1'b1, 1'b0, 4'd6));
        drain();
        cnt_clr_i = 1'b0;
        check("clr_sb", {16'd0, sb_cnt_o}, 32'd0);
        send(rq, pack(8'h77, 1'b1, 1'b0, 4'd6));
        drain();
        check_cnt("after_clr");

        // reset with two words in flight
        send(enc(8'h81), pack(8'h81, 1'b0, 1'b0, 4'd0));
        send(enc(8'h82), pack(8'h82, 1'b0, 1'b0, 4'd0));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        exp_q.delete();
        lat_q.delete();
        exp_sb = 0;
        exp_db = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check_cnt("post_rst");
        @(posedge clk);
        #1;
        send(enc(8'hC3), pack(8'hC3, 1'b0, 1'b0, 4'd0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
